// File: rtl/division_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : division_unit_pkg
// Description : Shared types and constants for the iterative divider:
//               FSM state encoding, status-flag bit positions, iteration
//               count and the flag-update mask.
// Revision    : 1.0 - initial release
// ============================================================================
package division_unit_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Bit positions inside the {V,N,C,Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // One restoring step per quotient bit
    localparam int DIV_ITERATIONS = 32;

    // Flags written back on a completed division: V, N and Z (C untouched)
    localparam logic [3:0] DIV_FLAGS_MASK = 4'b1101;

    // Absolute value of an operand when it is interpreted as signed
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        is_signed);
        return (is_signed && value[31]) ? (32'd0 - value) : value;
    endfunction

endpackage : division_unit_pkg
`default_nettype wire

// File: rtl/division_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift-subtract step on unsigned magnitudes.
//               The next dividend bit is shifted out of the top of the
//               quotient register into the partial remainder; if the
//               divisor fits, it is subtracted and a 1 enters the quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] den_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    // 33 bits: the shifted remainder can exceed 32 bits when the divisor
    // is close to 2^32, but the trial difference always fits back in 32.
    logic [32:0] shift_w;
    logic [32:0] diff_w;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        shift_w = {rem_i, quo_i[31]};
        diff_w  = shift_w - {1'b0, den_i};
        quo_o   = {quo_i[30:0], 1'b0};
        rem_o   = shift_w[31:0];
        if (!diff_w[32]) begin
            rem_o    = diff_w[31:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/division_unit.sv
`default_nettype none
// ============================================================================
// Module      : division_unit
// Description : 32-bit signed/unsigned restoring divider, one quotient bit
//               per cycle. Operands are reduced to magnitudes on entry, the
//               signs are reapplied in a single FIX cycle, and the results
//               plus status flags are presented with a one-cycle done pulse.
//               Divide-by-zero short-circuits straight to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module division_unit
    import division_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        isSigned,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [3:0]  outFlags,
    output logic [3:0]  outFlagsMask,
    output logic        setDivisionBy0
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_ITERATIONS - 1);

    div_state_e  state_q,     state_d;
    logic [5:0]  count_q,     count_d;
    logic [31:0] rem_q,       rem_d;        // working partial remainder
    logic [31:0] quo_q,       quo_d;        // working quotient / dividend bits
    logic [31:0] den_q,       den_d;        // divisor magnitude
    logic        neg_quo_q,   neg_quo_d;
    logic        neg_rem_q,   neg_rem_d;
    logic        ovf_q,       ovf_d;
    logic        div0_q,      div0_d;
    logic [31:0] quotient_q,  quotient_d;   // visible results, held across runs
    logic [31:0] remainder_q, remainder_d;
    logic [3:0]  flags_q,     flags_d;

    logic [31:0] step_rem_w;
    logic [31:0] step_quo_w;
    logic [31:0] fix_quo_w;
    logic [31:0] fix_rem_w;

    div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .den_i (den_q),
        .rem_o (step_rem_w),
        .quo_o (step_quo_w)
    );

    // Sign restoration applied when leaving the iteration phase
    always_comb begin
        fix_quo_w = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        fix_rem_w = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    end

    // Register all state; reset clears results, flags and the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            den_q       <= den_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            flags_q     <= flags_d;
        end
    end

    // Next-state logic: accept, iterate, fix signs, report; flush aborts
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        den_d       = den_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_d       = ovf_q;
        div0_d      = div0_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        flags_d     = flags_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        state_d     = DONE;
                        div0_d      = 1'b1;
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = dividend;
                        flags_d     = '0;
                    end else begin
                        state_d   = CALC;
                        div0_d    = 1'b0;
                        count_d   = '0;
                        rem_d     = '0;
                        quo_d     = magnitude(dividend, isSigned);
                        den_d     = magnitude(divisor, isSigned);
                        neg_quo_d = isSigned && (dividend[31] != divisor[31]);
                        neg_rem_d = isSigned && dividend[31];
                        // The one signed quotient that cannot be represented
                        ovf_d     = isSigned && (dividend == 32'h8000_0000)
                                             && (divisor == 32'hFFFF_FFFF);
                    end
                end
            end
            CALC: begin
                rem_d = step_rem_w;
                quo_d = step_quo_w;
                if (count_q == LAST_STEP) begin
                    count_d = '0;
                    state_d = FIX;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
            FIX: begin
                quotient_d          = fix_quo_w;
                remainder_d         = fix_rem_w;
                flags_d             = '0;
                flags_d[FLAG_Z]     = (fix_quo_w == 32'd0);
                flags_d[FLAG_N]     = fix_quo_w[31];
                flags_d[FLAG_C]     = 1'b0;
                flags_d[FLAG_V]     = ovf_q;
                state_d             = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: back to IDLE with the visible results left untouched
        if (flush) begin
            state_d     = IDLE;
            count_d     = '0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            flags_d     = flags_q;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy           = (state_q == CALC) || (state_q == FIX);
        done           = (state_q == DONE);
        setDivisionBy0 = (state_q == DONE) && div0_q;
        outFlagsMask   = ((state_q == DONE) && !div0_q) ? DIV_FLAGS_MASK : 4'b0000;
        quotient       = quotient_q;
        remainder      = remainder_q;
        outFlags       = flags_q;
    end

endmodule : division_unit
`default_nettype wire

// File: tb/tb_division_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_division_unit
// Description : Directed self-checking bench for division_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_division_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        isSigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [3:0]  outFlags;
    logic [3:0]  outFlagsMask;
    logic        setDivisionBy0;

    int n_cmp = 0;
    int n_err = 0;

    division_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .isSigned       (isSigned),
        .dividend       (dividend),
        .divisor        (divisor),
        .flush          (flush),
        .busy           (busy),
        .done           (done),
        .quotient       (quotient),
        .remainder      (remainder),
        .outFlags       (outFlags),
        .outFlagsMask   (outFlagsMask),
        .setDivisionBy0 (setDivisionBy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start (sampled at edge 0) and observe cycles 1..40.
    // Entered and left #1 after a rising edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int dcyc, output int ndone,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic [3:0] f, output logic [3:0] m, output logic dz,
                          output logic b1, output logic b33, output logic b34);
        dcyc = -1; ndone = 0; q = 'x; r = 'x; f = 'x; m = 'x; dz = 1'bx;
        b1 = 1'bx; b33 = 1'bx; b34 = 1'bx;
        dividend = a; divisor = b; isSigned = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 1)  b1  = busy;
            if (c == 33) b33 = busy;
            if (c == 34) b34 = busy;
            if (done === 1'b1) begin
                ndone++;
                if (dcyc < 0) begin
                    dcyc = c; q = quotient; r = remainder;
                    f = outFlags; m = outFlagsMask; dz = setDivisionBy0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; isSigned = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (setDivisionBy0 !== 1'b0) begin n_err++; $display("FAIL reset_dz got %b want 0", setDivisionBy0); end
        n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL reset_q got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL reset_r got %h want 0", remainder); end
        n_cmp++; if (outFlags !== 4'd0) begin n_err++; $display("FAIL reset_flags got %b want 0000", outFlags); end
        n_cmp++; if (outFlagsMask !== 4'd0) begin n_err++; $display("FAIL reset_mask got %b want 0000", outFlagsMask); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int dc, nd; logic [31:0] q, r; logic [3:0] f, m; logic dz, b1, b33, b34;
        run_op(32'd100, 32'd7, 1'b0, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (dc != 34) begin n_err++; $display("FAIL u100_7_done_cycle got %0d want 34", dc); end
        n_cmp++; if (nd != 1) begin n_err++; $display("FAIL u100_7_done_count got %0d want 1", nd); end
        n_cmp++; if (q !== 32'd14) begin n_err++; $display("FAIL u100_7_q got %h want 0000000e", q); end
        n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL u100_7_r got %h want 00000002", r); end
        n_cmp++; if (f !== 4'b0000) begin n_err++; $display("FAIL u100_7_flags got %b want 0000", f); end
        n_cmp++; if (m !== 4'b1101) begin n_err++; $display("FAIL u100_7_mask got %b want 1101", m); end
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL u100_7_dz got %b want 0", dz); end
        n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL u100_7_busy1 got %b want 1", b1); end
        n_cmp++; if (b33 !== 1'b1) begin n_err++; $display("FAIL u100_7_busy33 got %b want 1", b33); end
        n_cmp++; if (b34 !== 1'b0) begin n_err++; $display("FAIL u100_7_busy34 got %b want 0", b34); end
        n_cmp++; if (outFlagsMask !== 4'b0000) begin n_err++; $display("FAIL u100_7_mask_idle got %b want 0000", outFlagsMask); end
        // Large unsigned operands must not be treated as negative
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (q !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL uffff_16_q got %h want 0fffffff", q); end
        n_cmp++; if (r !== 32'hF) begin n_err++; $display("FAIL uffff_16_r got %h want 0000000f", r); end
        n_cmp++; if (f !== 4'b0000) begin n_err++; $display("FAIL uffff_16_flags got %b want 0000", f); end
        run_op(32'd5, 32'hFFFF_FFFF, 1'b0, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (q !== 32'd0) begin n_err++; $display("FAIL u5_max_q got %h want 0", q); end
        n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL u5_max_r got %h want 5", r); end
        n_cmp++; if (f !== 4'b0001) begin n_err++; $display("FAIL u5_max_flags got %b want 0001", f); end
    endtask

    task automatic test_signed();
        int dc, nd; logic [31:0] q, r; logic [3:0] f, m; logic dz, b1, b33, b34;
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (dc != 34) begin n_err++; $display("FAIL sm100_7_done_cycle got %0d want 34", dc); end
        n_cmp++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL sm100_7_q got %h want fffffff2", q); end
        n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sm100_7_r got %h want fffffffe", r); end
        n_cmp++; if (f !== 4'b0100) begin n_err++; $display("FAIL sm100_7_flags got %b want 0100", f); end
        // Negative divisor only: quotient negated, remainder keeps dividend sign
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (q !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL s7_m2_q got %h want fffffffd", q); end
        n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL s7_m2_r got %h want 00000001", r); end
    endtask

    task automatic test_overflow();
        int dc, nd; logic [31:0] q, r; logic [3:0] f, m; logic dz, b1, b33, b34;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (q !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_q got %h want 80000000", q); end
        n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL ovf_r got %h want 0", r); end
        n_cmp++; if (f !== 4'b1100) begin n_err++; $display("FAIL ovf_flags got %b want 1100", f); end
        n_cmp++; if (m !== 4'b1101) begin n_err++; $display("FAIL ovf_mask got %b want 1101", m); end
    endtask

    task automatic test_div0();
        int dc, nd; logic [31:0] q, r; logic [3:0] f, m; logic dz, b1, b33, b34;
        run_op(32'h1234, 32'd0, 1'b0, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL div0_done_cycle got %0d want 1", dc); end
        n_cmp++; if (nd != 1) begin n_err++; $display("FAIL div0_done_count got %0d want 1", nd); end
        n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL div0_dz got %b want 1", dz); end
        n_cmp++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_q got %h want ffffffff", q); end
        n_cmp++; if (r !== 32'h1234) begin n_err++; $display("FAIL div0_r got %h want 00001234", r); end
        n_cmp++; if (m !== 4'b0000) begin n_err++; $display("FAIL div0_mask got %b want 0000", m); end
        n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL div0_busy got %b want 0", b1); end
    endtask

    // Relies on test_div0 having left quotient=ffffffff, remainder=1234
    task automatic test_flush();
        int nd; int dc; logic [31:0] q, r; logic [3:0] f, m; logic dz, b1, b33, b34;
        nd = 0;
        dividend = 32'd7; divisor = 32'd7; isSigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done === 1'b1 || setDivisionBy0 === 1'b1) nd++;
            start = (c == 10);
            flush = (c == 20);
            if (c == 21) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
            end
        end
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (nd != 0) begin n_err++; $display("FAIL flush_done_count got %0d want 0", nd); end
        n_cmp++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL flush_q got %h want ffffffff", quotient); end
        n_cmp++; if (remainder !== 32'h1234) begin n_err++; $display("FAIL flush_r got %h want 00001234", remainder); end
        run_op(32'd0, 32'd5, 1'b0, dc, nd, q, r, f, m, dz, b1, b33, b34);
        n_cmp++; if (dc != 34) begin n_err++; $display("FAIL post_flush_done_cycle got %0d want 34", dc); end
        n_cmp++; if (q !== 32'd0) begin n_err++; $display("FAIL post_flush_q got %h want 0", q); end
        n_cmp++; if (f !== 4'b0001) begin n_err++; $display("FAIL post_flush_flags got %b want 0001", f); end
    endtask

    task automatic test_flush_start_idle();
        int nd;
        nd = 0;
        dividend = 32'd9; divisor = 32'd3; isSigned = 1'b0;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got %b want 0", busy); end
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) nd++;
            @(posedge clk); #1;
        end
        n_cmp++; if (nd != 0) begin n_err++; $display("FAIL flush_start_done got %0d want 0", nd); end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        dividend = 32'd100; divisor = 32'd7; isSigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done === 1'b1) nd++;
        end
        rst = 1'b1; flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
        n_cmp++; if (quotient !== 32'd0) begin n_err++; $display("FAIL rstmid_q got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'd0) begin n_err++; $display("FAIL rstmid_r got %h want 0", remainder); end
        n_cmp++; if (outFlags !== 4'd0) begin n_err++; $display("FAIL rstmid_flags got %b want 0000", outFlags); end
        n_cmp++; if (outFlagsMask !== 4'd0) begin n_err++; $display("FAIL rstmid_mask got %b want 0000", outFlagsMask); end
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) nd++;
            @(posedge clk); #1;
        end
        n_cmp++; if (nd != 0) begin n_err++; $display("FAIL rstmid_done_count got %0d want 0", nd); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; isSigned = 1'b0;
        dividend = '0; divisor = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div0();
        test_flush();
        test_flush_start_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_division_unit
`default_nettype wire
